// File: rtl/ps2_kb_decoder.sv
// PS/2 scan-code set 2 decoder: folds E0/F0 prefixes into {ext, brk, code}
// events and queues them in a small FIFO that throttles the receiver.
module ps2_kb_decoder #(
  parameter int W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] scan_in,
  input  logic       rd,
  output logic       rx_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       overflow,
  output logic       err
);

  localparam int         DEPTH = 2 ** W;
  localparam logic [W:0] FULL  = (W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         w_push;
  logic [9:0]   w_data;
  logic         w_err_set;
  logic         w_pop;
  logic         w_full;
  logic         w_do_push;
  logic         w_drop;
  logic [9:0]   w_head;

  logic [9:0]   r_mem [DEPTH];
  logic [W-1:0] r_wptr;
  logic [W-1:0] r_rptr;
  logic [W:0]   r_count;
  logic         r_rx_en;
  logic         r_overflow;
  logic         r_err;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Prefix tracking and event assembly; repeated prefixes are absorbed.
  always_comb begin
    w_next    = r_state;
    w_push    = 1'b0;
    w_data    = 10'd0;
    w_err_set = 1'b0;
    if (rx_done_tick) begin
      case (r_state)
        ST_IDLE: begin
          case (scan_in)
            8'hE0:        w_next = ST_EXT;
            8'hF0:        w_next = ST_BRK;
            8'h00, 8'hFF: w_err_set = 1'b1;
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1: w_next = ST_IDLE;
            default: begin
              w_push = 1'b1;
              w_data = {2'b00, scan_in};
            end
          endcase
        end
        ST_EXT: begin
          case (scan_in)
            8'hF0:   w_next = ST_EXT_BRK;
            8'hE0:   w_next = ST_EXT;
            default: begin
              w_push = 1'b1;
              w_data = {2'b10, scan_in};
              w_next = ST_IDLE;
            end
          endcase
        end
        ST_BRK: begin
          case (scan_in)
            8'hF0:   w_next = ST_BRK;
            8'hE0:   w_next = ST_EXT_BRK;
            default: begin
              w_push = 1'b1;
              w_data = {2'b01, scan_in};
              w_next = ST_IDLE;
            end
          endcase
        end
        ST_EXT_BRK: begin
          case (scan_in)
            8'hE0, 8'hF0: w_next = ST_EXT_BRK;
            default: begin
              w_push = 1'b1;
              w_data = {2'b11, scan_in};
              w_next = ST_IDLE;
            end
          endcase
        end
        default: w_next = ST_IDLE;
      endcase
    end else begin
      w_next = r_state;
    end
  end

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_pop     = rd && (r_count != (W + 1)'(0));
  assign w_full    = (r_count == FULL);
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // FIFO storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= w_data;
    end
  end

  // Pointers, occupancy, receiver enable and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rx_en    <= 1'b1;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + W'(1);
      end
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + (W + 1)'(1);
        2'b01:   r_count <= r_count - (W + 1)'(1);
        default: r_count <= r_count;
      endcase
      r_rx_en <= (r_count != FULL);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_head    = r_mem[r_rptr];
  assign key_valid = (r_count != (W + 1)'(0));
  assign key_code  = key_valid ? w_head[7:0] : 8'h00;
  assign key_ext   = key_valid ? w_head[9]   : 1'b0;
  assign key_brk   = key_valid ? w_head[8]   : 1'b0;
  assign rx_en     = r_rx_en;
  assign overflow  = r_overflow;
  assign err       = r_err;

endmodule

// File: tb/tb_ps2_kb_decoder.sv
// Directed self-checking bench for ps2_kb_decoder (W=2, four-entry FIFO).
module tb_ps2_kb_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] scan_in = 8'h00;
  logic       rd = 1'b0;
  logic       rx_en;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       overflow;
  logic       err;

  int total = 0;
  int bad   = 0;

  ps2_kb_decoder #(.W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .scan_in      (scan_in),
    .rd           (rd),
    .rx_en        (rx_en),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_brk      (key_brk),
    .overflow     (overflow),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Head entry as {valid, ext, brk, code}.
  task automatic chk_head(input string tag, input logic [10:0] exp);
    chk(tag, {21'd0, key_valid, key_ext, key_brk, key_code}, {21'd0, exp});
  endtask

  // Inputs change on the falling edge; return on the next falling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    scan_in      = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // 1. reset values, then first make code
    repeat (3) @(negedge clk);
    chk_head("rst_head_in", {1'b0, 1'b0, 1'b0, 8'h00});
    chk("rst_rx_en_in", {31'd0, rx_en}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_rx_en", {31'd0, rx_en}, 32'd1);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    send(8'h1C);
    chk_head("t1_make", {1'b1, 1'b0, 1'b0, 8'h1C});
    pop();
    chk("t1_popped", {31'd0, key_valid}, 32'd0);

    // 2. break, extended make, extended break
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk_head("t2_e0", {1'b1, 1'b0, 1'b1, 8'h1C});
    pop();
    chk_head("t2_e1", {1'b1, 1'b1, 1'b0, 8'h75});
    pop();
    chk_head("t2_e2", {1'b1, 1'b1, 1'b1, 8'h75});
    pop();
    chk("t2_empty", {31'd0, key_valid}, 32'd0);

    // repeated prefixes and F0-then-E0 ordering
    send(8'hE0); send(8'hE0); send(8'hF0); send(8'hF0); send(8'hE0); send(8'h12);
    chk_head("t2_rep", {1'b1, 1'b1, 1'b1, 8'h12});
    pop();
    send(8'hF0); send(8'hF0); send(8'h14);
    chk_head("t2_brkbrk", {1'b1, 1'b0, 1'b1, 8'h14});
    pop();
    send(8'hF0); send(8'hE0); send(8'h14);
    chk_head("t2_brkext", {1'b1, 1'b1, 1'b1, 8'h14});
    pop();
    chk("t2_empty2", {31'd0, key_valid}, 32'd0);

    // 3. fill to four entries, then overflow
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    @(negedge clk);
    chk("t3_rx_en_full", {31'd0, rx_en}, 32'd0);
    chk("t3_ovf_before", {31'd0, overflow}, 32'd0);
    send(8'h2C);
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    chk_head("t3_head", {1'b1, 1'b0, 1'b0, 8'h15});

    // 4. push and pop together while full
    do_reset();
    chk("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    @(negedge clk);
    rd = 1'b1; rx_done_tick = 1'b1; scan_in = 8'h2C;
    @(negedge clk);
    rd = 1'b0; rx_done_tick = 1'b0;
    chk("t4_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    chk("t4_rx_en", {31'd0, rx_en}, 32'd0);
    chk_head("t4_h0", {1'b1, 1'b0, 1'b0, 8'h1D});
    pop();
    chk_head("t4_h1", {1'b1, 1'b0, 1'b0, 8'h24});
    pop();
    chk_head("t4_h2", {1'b1, 1'b0, 1'b0, 8'h2D});
    pop();
    chk_head("t4_h3", {1'b1, 1'b0, 1'b0, 8'h2C});
    pop();
    chk("t4_empty", {31'd0, key_valid}, 32'd0);
    @(negedge clk);
    chk("t4_rx_en_back", {31'd0, rx_en}, 32'd1);

    // 5. discarded bytes and error byte
    send(8'hAA); send(8'hFA); send(8'hEE); send(8'hFE); send(8'hE1);
    chk("t5_discard", {31'd0, key_valid}, 32'd0);
    chk("t5_no_err", {31'd0, err}, 32'd0);
    send(8'h00);
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_err_nopush", {31'd0, key_valid}, 32'd0);
    send(8'h1C);
    chk_head("t5_after", {1'b1, 1'b0, 1'b0, 8'h1C});
    chk("t5_err_sticky", {31'd0, err}, 32'd1);
    pop();

    // 6. reset mid-sequence, then pop while empty
    send(8'hE0);
    do_reset();
    chk("t6_err_cleared", {31'd0, err}, 32'd0);
    send(8'h75);
    chk_head("t6_noext", {1'b1, 1'b0, 1'b0, 8'h75});
    pop();
    chk("t6_empty", {31'd0, key_valid}, 32'd0);
    pop();
    chk("t6_empty_pop", {31'd0, key_valid}, 32'd0);
    send(8'h1C);
    chk_head("t6_after", {1'b1, 1'b0, 1'b0, 8'h1C});
    pop();
    chk("t6_final_empty", {31'd0, key_valid}, 32'd0);

    // same-cycle push and pop while empty: pop ignored
    @(negedge clk);
    rd = 1'b1; rx_done_tick = 1'b1; scan_in = 8'h33;
    @(negedge clk);
    rd = 1'b0; rx_done_tick = 1'b0;
    chk_head("t6_pushpop_empty", {1'b1, 1'b0, 1'b0, 8'h33});
    pop();
    chk("t6_count_one", {31'd0, key_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_kb_decoder.md
Name: ps2_kb_decoder

Overview:
- Consumes the byte stream from the PS/2 receiver (`rx_done_tick`, `dout`) and interprets keyboard scan-code set 2 sequences.
- Handles the E0 extended prefix and the F0 break prefix. Each complete key event is packed as {ext, brk, code} and pushed into a small FIFO for the downstream keyboard logic (ASCII mapper, display).
- Drives the receiver's `rx_en` so that it only accepts bytes while the FIFO has room.

Parameters:
- W, 2, FIFO address width; FIFO depth = 2**W (default 4 entries).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- rx_done_tick  input  1  one-cycle strobe from the PS/2 receiver: new byte on scan_in
- scan_in  input  8  received byte (receiver dout)
- rd  input  1  pop request; honoured only when key_valid=1
- rx_en  output  1  enable to the receiver; 1 when FIFO not full
- key_valid  output  1  FIFO not empty
- key_code  output  8  head entry scan code
- key_ext  output  1  head entry had E0 prefix
- key_brk  output  1  head entry is a release (F0 prefix)
- overflow  output  1  sticky: an event was dropped because the FIFO was full
- err  output  1  sticky: keyboard error byte (0x00 or 0xFF) received

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE; FIFO pointers and count to 0.
  - overflow=0, err=0, key_valid=0, rx_en=1.
  - key_code/key_ext/key_brk read 0 (FIFO storage not cleared; outputs gated by key_valid=0).
- Bytes are processed only in a cycle with rx_done_tick=1; otherwise the FSM holds.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  - IDLE:
    - 0xE0 -> EXT.
    - 0xF0 -> BRK.
    - 0x00/0xFF -> set err, stay IDLE, no push.
    - 0xAA, 0xFA, 0xEE, 0xFE, 0xE1 -> discard, stay IDLE.
    - Any other byte -> push {0,0,byte}, stay IDLE.
  - EXT:
    - 0xF0 -> EXT_BRK.
    - 0xE0 -> stay EXT.
    - Other -> push {1,0,byte}, go IDLE.
  - BRK:
    - 0xF0 -> stay BRK.
    - 0xE0 -> EXT_BRK.
    - Other -> push {0,1,byte}, go IDLE.
  - EXT_BRK:
    - 0xE0/0xF0 -> stay.
    - Other -> push {1,1,byte}, go IDLE.
- Push timing: the entry is written on the clock edge ending the rx_done_tick cycle. key_valid rises the following cycle (1-cycle latency, byte-strobe to visible).
- FIFO:
  - Entries are 10 bits, circular buffer with W-bit read/write pointers that wrap modulo 2**W, plus a (W+1)-bit count.
  - Outputs show the head entry combinationally from storage.
  - Pop: rd=1 with key_valid=1 advances the read pointer at the clock edge. rd=1 when empty is ignored.
  - Push when full: entry dropped, overflow set; FSM still returns to IDLE.
  - Push and pop in the same cycle when full: pop frees the slot, push succeeds, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push succeeds, pop ignored, count becomes 1.
- rx_en = (count != 2**W), registered from count; rx_en=0 the cycle after the FIFO becomes full.
- overflow and err clear only on reset.
- Reset mid-sequence (e.g. after E0): prefix state is lost; the next byte is interpreted from IDLE.

Test Plan:
1. Reset with reset=0, then release -> key_valid=0, rx_en=1, overflow=0, err=0; then byte 0x1C -> next cycle key_valid=1, key_code=0x1C, ext=0, brk=0.
2. Bytes F0,1C then E0,75 then E0,F0,75 -> three entries in order:
   - {0,1,0x1C}
   - {1,0,0x75}
   - {1,1,0x75}
   - Pop each with rd; key_valid=0 after the third pop.
3. W=2: push 4 make codes 0x15,0x1D,0x24,0x2D -> rx_en=0 the following cycle. Force a 5th strobe 0x2C -> dropped, overflow=1, head still 0x15.
4. FIFO full, rd=1 in the same cycle as strobe 0x2C -> count stays 4, overflow stays 0, last entry is 0x2C.
5. Bytes AA, FA, 00 -> no entries, err=1; following 0x1C is pushed normally.
6. Byte E0, then reset pulse, then 0x75 -> entry {0,0,0x75}; rd asserted while empty -> pointers unchanged.
